// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator for a raster-scan pixel stream: two line buffers
// plus a 3x3 shift window, emitting only fully-populated (valid-mode) windows.
module conv_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_valid,
  input  logic                        pix_sof,
  input  logic signed [DATA_W-1:0]    pix_in,
  output logic [8:0][DATA_W-1:0]      window_out,
  output logic                        load,
  output logic [$clog2(IMG_H)-1:0]    win_row,
  output logic [$clog2(IMG_W)-1:0]    win_col,
  output logic                        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // Handshake: pix_valid qualifies pix_in/pix_sof and every valid beat is
  // consumed on the rising edge (no ready). load/frame_done are one-cycle
  // strobes with no backpressure; window_out/win_row/win_col are stable while
  // load is high and hold their value until the next accepted pixel.

  logic [CW-1:0]     col_q, eff_col, col_n;
  logic [RW-1:0]     row_q, eff_row, row_n;
  logic              last_col, last_row, win_ok;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];

  // sof forces the current pixel to (0,0) regardless of counter state
  always_comb begin
    eff_col  = pix_sof ? '0 : col_q;
    eff_row  = pix_sof ? '0 : row_q;
    last_col = (eff_col == CW'(IMG_W - 1));
    last_row = (eff_row == RW'(IMG_H - 1));
    col_n    = last_col ? '0 : eff_col + CW'(1);
    row_n    = eff_row;
    if (last_col) begin
      row_n = last_row ? '0 : eff_row + RW'(1);
    end
    win_ok   = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
  end

  // Line buffer RAM is intentionally not reset; windows never reach stale rows.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[eff_col] <= lb0[eff_col];
      lb0[eff_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      load       <= 1'b0;
      frame_done <= 1'b0;
      window_out <= '0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      load       <= pix_valid && win_ok;
      frame_done <= pix_valid && win_ok && last_row && last_col;
      if (pix_valid) begin
        col_q <= col_n;
        row_q <= row_n;
        for (int r = 0; r < 3; r++) begin
          window_out[r*3]   <= window_out[r*3+1];
          window_out[r*3+1] <= window_out[r*3+2];
        end
        window_out[2] <= lb1[eff_col];
        window_out[5] <= lb0[eff_col];
        window_out[8] <= pix_in;
        if (win_ok) begin
          win_row <= eff_row - RW'(2);
          win_col <= eff_col - CW'(2);
        end
      end
    end
  end

endmodule
